// File: rtl/rop_ba_pkg.sv
// Shared decode constants, FSM state and writeback encodings for the byte co-processor.
// Pure declarations: no logic, no latency.
// No flow control of its own; used by the top and its memory-port sub-module.
package rop_ba_pkg;

  // Custom opcode owned by this co-processor
  localparam logic [6:0] OPC_COP  = 7'b0101011;

  // funct3 selectors
  localparam logic [2:0] F3_SB    = 3'b000;
  localparam logic [2:0] F3_RTYPE = 3'b001;
  localparam logic [2:0] F3_LB    = 3'b010;
  localparam logic [2:0] F3_LBK   = 3'b011;

  // funct7 selectors for R-type; odd values broadcast rs2[7:0] to all lanes
  localparam logic [6:0] F7_XOR   = 7'b0000000;
  localparam logic [6:0] F7_XORK  = 7'b0000001;
  localparam logic [6:0] F7_AND   = 7'b0000010;
  localparam logic [6:0] F7_ANDK  = 7'b0000011;
  localparam logic [6:0] F7_OR    = 7'b0000100;
  localparam logic [6:0] F7_ORK   = 7'b0000101;

  // Writeback mode: full word, or byte write into a single lane
  localparam logic [2:0] RD_BYTE_WORD = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALU,
    ST_MEM,
    ST_RSP
  } state_e;

  typedef enum logic [2:0] {
    OP_ILLEGAL,
    OP_XOR,
    OP_AND,
    OP_OR,
    OP_LB,
    OP_LBK,
    OP_SB
  } op_e;

  // Byte-lane writeback code for a given lane
  function automatic logic [2:0] rd_byte_lane(input logic [1:0] lane);
    return {1'b1, lane};
  endfunction

endpackage

// File: rtl/rop_ba_cop_if.sv
// Host instruction handshake plus co-processor memory port bundled as one interface.
// No latency: wires only.
// slave = co-processor side, master = host/memory side.
interface rop_ba_cop_if;
  logic        clk_req;
  logic        cop_req;
  logic        cop_acc;
  logic        cop_rsp;
  logic [31:0] cop_instr_in;
  logic [31:0] cop_rs1;
  logic [31:0] cop_rs2;
  logic [2:0]  cop_rd_byte;
  logic [4:0]  cop_rd;
  logic [31:0] cop_wdata;
  logic        cop_wen;
  logic        cop_mem_ld_error;
  logic        cop_mem_st_error;
  logic        cop_mem_cen;
  logic        cop_mem_stall;
  logic        cop_mem_error;
  logic        cop_mem_wen;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_wdata;
  logic [31:0] cop_mem_rdata;
  logic [31:0] cop_mem_addr;

  modport slave (
    input  cop_req, cop_instr_in, cop_rs1, cop_rs2,
    input  cop_mem_stall, cop_mem_error, cop_mem_rdata,
    output clk_req, cop_acc, cop_rsp, cop_rd_byte, cop_rd, cop_wdata, cop_wen,
    output cop_mem_ld_error, cop_mem_st_error,
    output cop_mem_cen, cop_mem_wen, cop_mem_ben, cop_mem_wdata, cop_mem_addr
  );

  modport master (
    output cop_req, cop_instr_in, cop_rs1, cop_rs2,
    output cop_mem_stall, cop_mem_error, cop_mem_rdata,
    input  clk_req, cop_acc, cop_rsp, cop_rd_byte, cop_rd, cop_wdata, cop_wen,
    input  cop_mem_ld_error, cop_mem_st_error,
    input  cop_mem_cen, cop_mem_wen, cop_mem_ben, cop_mem_wdata, cop_mem_addr
  );
endinterface

// File: rtl/rop_ba_cop_mem.sv
// Memory-port sequencer: drives one byte load/store, handles stall/error, extracts the load lane.
// cen goes low the cycle after start; the transfer completes on the first edge with cen=0 and stall=0.
// While stall is high every port output is held; done/done_error/ld_byte are combinational.
module rop_ba_cop_mem (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        start_store,
  input  logic [31:0] start_addr,
  input  logic [7:0]  start_byte,
  output logic        mem_cen,
  output logic        mem_wen,
  output logic [3:0]  mem_ben,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic        mem_stall,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        done_error,
  output logic [7:0]  ld_byte
);

  assign done       = ~mem_cen & ~mem_stall;
  assign done_error = mem_error;

  // Launch the access on start, hold it through stalls, release the port when it completes
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      mem_cen   <= 1'b1;
      mem_wen   <= 1'b0;
      mem_ben   <= 4'b0000;
      mem_wdata <= 32'h0;
      mem_addr  <= 32'h0;
    end else if (start) begin
      mem_cen  <= 1'b0;
      mem_wen  <= start_store;
      mem_ben  <= start_store ? (4'b0001 << start_addr[1:0]) : 4'b0000;
      mem_addr <= start_addr;
      if (start_store) begin
        mem_wdata <= {4{start_byte}};
      end
    end else if (done) begin
      mem_cen <= 1'b1;
      mem_wen <= 1'b0;
      mem_ben <= 4'b0000;
    end
  end

  // Pick the addressed byte out of the returned word
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (mem_addr[1:0])
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
  end

endmodule

// File: rtl/rop_ba_cop.sv
// Byte co-processor top: decodes one custom instruction, runs the bitwise ALU or a byte load/store.
// ALU ops respond 2 cycles after accept; memory ops 2 cycles plus one per stall cycle.
// Accepts only in IDLE (cop_acc combinational); memory stalls freeze the MEM state.
module rop_ba_cop
  import rop_ba_pkg::*;
(
  input  logic         clk,
  input  logic         resetn,
  rop_ba_cop_if.slave  bus
);

  state_e      state;
  op_e         op_q;
  logic        bcast_q;
  logic [4:0]  rd_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;

  op_e         dec_op;
  logic        dec_bcast;
  logic        dec_mem;
  logic        dec_store;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [11:0] imm12;
  logic [31:0] ea;
  logic [31:0] opnd_b;
  logic        acc;

  logic        mem_done;
  logic        mem_err;
  logic [7:0]  ld_byte;
  logic [31:0] mem_addr;

  assign f7 = bus.cop_instr_in[31:25];
  assign f3 = bus.cop_instr_in[14:12];

  // Classify the incoming instruction word
  always_comb begin
    dec_op    = OP_ILLEGAL;
    dec_bcast = 1'b0;
    if (bus.cop_instr_in[6:0] == OPC_COP) begin
      case (f3)
        F3_RTYPE: begin
          case (f7)
            F7_XOR:  dec_op = OP_XOR;
            F7_XORK: begin dec_op = OP_XOR; dec_bcast = 1'b1; end
            F7_AND:  dec_op = OP_AND;
            F7_ANDK: begin dec_op = OP_AND; dec_bcast = 1'b1; end
            F7_OR:   dec_op = OP_OR;
            F7_ORK:  begin dec_op = OP_OR;  dec_bcast = 1'b1; end
            default: dec_op = OP_ILLEGAL;
          endcase
        end
        F3_LB:   dec_op = OP_LB;
        F3_LBK:  dec_op = OP_LBK;
        F3_SB:   dec_op = OP_SB;
        default: dec_op = OP_ILLEGAL;
      endcase
    end
  end

  assign dec_store = (dec_op == OP_SB);
  assign dec_mem   = (dec_op == OP_LB) | (dec_op == OP_LBK) | dec_store;
  // Stores split the immediate around the rd field
  assign imm12     = dec_store ? {bus.cop_instr_in[31:25], bus.cop_instr_in[11:7]}
                               : bus.cop_instr_in[31:20];
  assign ea        = bus.cop_rs1 + {{20{imm12[11]}}, imm12};

  // Reset gates acceptance so a held request is never acknowledged while in reset
  assign acc         = (state == ST_IDLE) & bus.cop_req & ~resetn;
  assign bus.cop_acc = acc;
  assign bus.clk_req = bus.cop_req | (state != ST_IDLE);

  assign opnd_b = bcast_q ? {4{rs2_q[7:0]}} : rs2_q;
  assign bus.cop_mem_addr = mem_addr;

  rop_ba_cop_mem u_mem (
    .clk         (clk),
    .resetn      (resetn),
    .start       (acc & dec_mem),
    .start_store (dec_store),
    .start_addr  (ea),
    .start_byte  (bus.cop_rs2[7:0]),
    .mem_cen     (bus.cop_mem_cen),
    .mem_wen     (bus.cop_mem_wen),
    .mem_ben     (bus.cop_mem_ben),
    .mem_wdata   (bus.cop_mem_wdata),
    .mem_addr    (mem_addr),
    .mem_stall   (bus.cop_mem_stall),
    .mem_error   (bus.cop_mem_error),
    .mem_rdata   (bus.cop_mem_rdata),
    .done        (mem_done),
    .done_error  (mem_err),
    .ld_byte     (ld_byte)
  );

  // Control FSM with registered writeback/response outputs
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state                <= ST_IDLE;
      op_q                 <= OP_ILLEGAL;
      bcast_q              <= 1'b0;
      rd_q                 <= 5'd0;
      rs1_q                <= 32'h0;
      rs2_q                <= 32'h0;
      bus.cop_rsp          <= 1'b0;
      bus.cop_wen          <= 1'b0;
      bus.cop_wdata        <= 32'h0;
      bus.cop_rd           <= 5'd0;
      bus.cop_rd_byte      <= RD_BYTE_WORD;
      bus.cop_mem_ld_error <= 1'b0;
      bus.cop_mem_st_error <= 1'b0;
    end else begin
      bus.cop_rsp <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc) begin
            op_q    <= dec_op;
            bcast_q <= dec_bcast;
            rd_q    <= bus.cop_instr_in[11:7];
            rs1_q   <= bus.cop_rs1;
            rs2_q   <= bus.cop_rs2;
            state   <= dec_mem ? ST_MEM : ST_ALU;
          end
        end
        ST_ALU: begin
          state                <= ST_RSP;
          bus.cop_rsp          <= 1'b1;
          bus.cop_rd           <= rd_q;
          bus.cop_rd_byte      <= RD_BYTE_WORD;
          bus.cop_mem_ld_error <= 1'b0;
          bus.cop_mem_st_error <= 1'b0;
          case (op_q)
            OP_XOR:  begin bus.cop_wdata <= rs1_q ^ opnd_b; bus.cop_wen <= 1'b1; end
            OP_AND:  begin bus.cop_wdata <= rs1_q & opnd_b; bus.cop_wen <= 1'b1; end
            OP_OR:   begin bus.cop_wdata <= rs1_q | opnd_b; bus.cop_wen <= 1'b1; end
            default: begin bus.cop_wdata <= 32'h0;          bus.cop_wen <= 1'b0; end
          endcase
        end
        ST_MEM: begin
          if (mem_done) begin
            state                <= ST_RSP;
            bus.cop_rsp          <= 1'b1;
            bus.cop_rd           <= rd_q;
            bus.cop_mem_ld_error <= (op_q != OP_SB) & mem_err;
            bus.cop_mem_st_error <= (op_q == OP_SB) & mem_err;
            bus.cop_wen          <= (op_q != OP_SB) & ~mem_err;
            if (op_q == OP_LBK) begin
              bus.cop_wdata   <= {4{ld_byte}};
              bus.cop_rd_byte <= rd_byte_lane(mem_addr[1:0]);
            end else if (op_q == OP_LB) begin
              bus.cop_wdata   <= {24'h0, ld_byte};
              bus.cop_rd_byte <= RD_BYTE_WORD;
            end else begin
              bus.cop_wdata   <= 32'h0;
              bus.cop_rd_byte <= RD_BYTE_WORD;
            end
          end
        end
        ST_RSP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rop_ba_cop.sv
// Randomised and directed bench for the byte co-processor against a behavioural model.
module tb_rop_ba_cop;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  rop_ba_cop_if bus ();

  rop_ba_cop dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct packed {
    logic        is_mem;
    logic        mwen;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] mwdata;
    logic        wen;
    logic [31:0] wdata;
    logic [2:0]  rd_byte;
    logic        lde;
    logic        ste;
  } exp_t;

  // Reference behaviour computed straight from the instruction semantics
  function automatic exp_t model(input logic [31:0] instr, rs1, rs2, rdata, input logic err);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] imm;
    logic [31:0] b, shifted;
    logic [7:0]  byt;
    int          lane;
    e  = '0;
    f3 = instr[14:12];
    f7 = instr[31:25];
    if (instr[6:0] == 7'h2B) begin
      if (f3 == 3'd1 && f7 <= 7'd5) begin
        b = f7[0] ? ({24'h0, rs2[7:0]} * 32'h0101_0101) : rs2;
        if (f7 / 2 == 0)      e.wdata = rs1 ^ b;
        else if (f7 / 2 == 1) e.wdata = rs1 & b;
        else                  e.wdata = rs1 | b;
        e.wen = 1'b1;
      end else if (f3 == 3'd2 || f3 == 3'd3 || f3 == 3'd0) begin
        e.is_mem = 1'b1;
        imm      = (f3 == 3'd0) ? {instr[31:25], instr[11:7]} : instr[31:20];
        e.addr   = rs1 + 32'($signed(imm));
        lane     = int'(e.addr % 4);
        if (f3 == 3'd0) begin
          e.mwen   = 1'b1;
          e.ben    = 4'(1 << lane);
          e.mwdata = {24'h0, rs2[7:0]} * 32'h0101_0101;
          e.ste    = err;
        end else begin
          shifted = rdata >> (8 * lane);
          byt     = shifted[7:0];
          e.wdata = (f3 == 3'd2) ? {24'h0, byt} : {24'h0, byt} * 32'h0101_0101;
          e.rd_byte = (f3 == 3'd2) ? 3'd0 : 3'(4 + lane);
          e.wen   = ~err;
          e.lde   = err;
        end
      end
    end
    return e;
  endfunction

  // Drive one instruction through the handshake and check every observable effect
  task automatic do_txn(input logic [31:0] instr, rs1, rs2, rdata,
                        input int stalls, input logic err, input bit b2b);
    exp_t e;
    int   k, cen_cnt, exp_k, exp_cen;
    bit   got;
    e = model(instr, rs1, rs2, rdata, err);
    if (!b2b) @(negedge clk);
    bus.cop_req       = 1'b1;
    bus.cop_instr_in  = instr;
    bus.cop_rs1       = rs1;
    bus.cop_rs2       = rs2;
    bus.cop_mem_rdata = rdata;
    bus.cop_mem_error = err;
    bus.cop_mem_stall = 1'b0;
    #1;
    if (b2b) begin
      checks++;
      if (bus.cop_acc !== 1'b0) begin errors++; $display("FAIL acc_in_rsp: got %b want 0", bus.cop_acc); end
      @(negedge clk); #1;
      checks++;
      if (bus.cop_rsp !== 1'b0) begin errors++; $display("FAIL rsp_width: got %b want 0", bus.cop_rsp); end
    end
    checks++;
    if (bus.cop_acc !== 1'b1) begin errors++; $display("FAIL acc: got %b want 1 instr=%h", bus.cop_acc, instr); end
    k = 0; cen_cnt = 0; got = 0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.cop_rsp === 1'b1) begin
        got = 1;
      end else begin
        checks++;
        if (bus.cop_acc !== 1'b0 || bus.clk_req !== 1'b1)
          begin errors++; $display("FAIL busy_flags: acc=%b clk_req=%b want 0/1", bus.cop_acc, bus.clk_req); end
        if (bus.cop_mem_cen === 1'b0) begin
          checks++;
          if (bus.cop_mem_addr !== e.addr || bus.cop_mem_wen !== e.mwen || bus.cop_mem_ben !== e.ben ||
              (e.mwen && bus.cop_mem_wdata !== e.mwdata))
            begin errors++; $display("FAIL mem_port: addr=%h wen=%b ben=%b wd=%h want %h %b %b %h",
              bus.cop_mem_addr, bus.cop_mem_wen, bus.cop_mem_ben, bus.cop_mem_wdata, e.addr, e.mwen, e.ben, e.mwdata); end
          bus.cop_mem_stall = (cen_cnt < stalls);
          cen_cnt++;
        end else begin
          bus.cop_mem_stall = 1'b0;
        end
      end
    end
    bus.cop_mem_stall = 1'b0;
    bus.cop_req       = 1'b0;
    exp_k   = e.is_mem ? 2 + stalls : 2;
    exp_cen = e.is_mem ? 1 + stalls : 0;
    checks++;
    if (k !== exp_k) begin errors++; $display("FAIL latency: got %0d want %0d instr=%h", k, exp_k, instr); end
    checks++;
    if (cen_cnt !== exp_cen) begin errors++; $display("FAIL cen_cycles: got %0d want %0d", cen_cnt, exp_cen); end
    if (got) begin
      checks++;
      if (bus.cop_wen !== e.wen) begin errors++; $display("FAIL wen: got %b want %b instr=%h", bus.cop_wen, e.wen, instr); end
      checks++;
      if (bus.cop_mem_ld_error !== e.lde || bus.cop_mem_st_error !== e.ste)
        begin errors++; $display("FAIL err_flags: got %b%b want %b%b", bus.cop_mem_ld_error, bus.cop_mem_st_error, e.lde, e.ste); end
      if (e.wen) begin
        checks++;
        if (bus.cop_wdata !== e.wdata || bus.cop_rd !== instr[11:7] || bus.cop_rd_byte !== e.rd_byte)
          begin errors++; $display("FAIL writeback: wd=%h rd=%0d rb=%b want %h %0d %b",
            bus.cop_wdata, bus.cop_rd, bus.cop_rd_byte, e.wdata, instr[11:7], e.rd_byte); end
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    bus.cop_req = 1'b0; bus.cop_instr_in = 32'h0; bus.cop_rs1 = 32'h0; bus.cop_rs2 = 32'h0;
    bus.cop_mem_stall = 1'b0; bus.cop_mem_error = 1'b0; bus.cop_mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.cop_acc, bus.cop_rsp, bus.cop_wen, bus.cop_mem_ld_error, bus.cop_mem_st_error, bus.clk_req} !== 6'b0)
      begin errors++; $display("FAIL reset_flags: got %b want 000000", {bus.cop_acc, bus.cop_rsp, bus.cop_wen,
        bus.cop_mem_ld_error, bus.cop_mem_st_error, bus.clk_req}); end
    checks++;
    if (bus.cop_mem_cen !== 1'b1 || bus.cop_mem_wen !== 1'b0 || bus.cop_mem_ben !== 4'b0)
      begin errors++; $display("FAIL reset_mem: cen=%b wen=%b ben=%b want 1 0 0000", bus.cop_mem_cen, bus.cop_mem_wen, bus.cop_mem_ben); end
    checks++;
    if (bus.cop_rd !== 5'd0 || bus.cop_rd_byte !== 3'd0 || bus.cop_wdata !== 32'h0 ||
        bus.cop_mem_wdata !== 32'h0 || bus.cop_mem_addr !== 32'h0)
      begin errors++; $display("FAIL reset_data: rd=%0d rb=%b wd=%h mwd=%h ma=%h want zeros",
        bus.cop_rd, bus.cop_rd_byte, bus.cop_wdata, bus.cop_mem_wdata, bus.cop_mem_addr); end
    bus.cop_req = 1'b1; bus.cop_instr_in = 32'h0000_102B;
    #1;
    checks++;
    if (bus.cop_acc !== 1'b0) begin errors++; $display("FAIL acc_during_reset: got %b want 0", bus.cop_acc); end
    bus.cop_req = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
  endtask

  task automatic test_xor_rb();
    do_txn({7'd0, 5'd2, 5'd1, 3'b001, 5'd5, 7'h2B}, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h0, 0, 1'b0, 1'b0);
    checks++;
    if (bus.cop_wdata !== 32'hFF00_12CB || bus.cop_rd !== 5'd5)
      begin errors++; $display("FAIL xor_rb: wd=%h rd=%0d want ff0012cb 5", bus.cop_wdata, bus.cop_rd); end
  endtask

  task automatic test_and_rbk();
    do_txn({7'd3, 5'd2, 5'd1, 3'b001, 5'd6, 7'h2B}, 32'h1234_5678, 32'hAAAA_AA0F, 32'h0, 0, 1'b0, 1'b0);
    checks++;
    if (bus.cop_wdata !== 32'h0204_0608) begin errors++; $display("FAIL and_rbk: got %h want 02040608", bus.cop_wdata); end
  endtask

  task automatic test_lb_bk();
    do_txn({12'd3, 5'd1, 3'b011, 5'd7, 7'h2B}, 32'h0000_0100, 32'h0, 32'hDE00_0000, 0, 1'b0, 1'b0);
    checks++;
    if (bus.cop_wdata !== 32'hDEDE_DEDE || bus.cop_rd_byte !== 3'b111)
      begin errors++; $display("FAIL lb_bk: wd=%h rb=%b want dededede 111", bus.cop_wdata, bus.cop_rd_byte); end
  endtask

  task automatic test_sb_stall();
    do_txn({7'h7F, 5'd2, 5'd1, 3'b000, 5'h1F, 7'h2B}, 32'h0000_0200, 32'h0000_0055, 32'h0, 3, 1'b0, 1'b0);
    checks++;
    if (bus.cop_wen !== 1'b0) begin errors++; $display("FAIL sb_wen: got %b want 0", bus.cop_wen); end
  endtask

  task automatic test_lb_error_b2b();
    do_txn({12'h006, 5'd1, 3'b010, 5'd9, 7'h2B}, 32'h0000_0040, 32'h0, 32'h1234_5678, 1, 1'b1, 1'b0);
    checks++;
    if (bus.cop_mem_ld_error !== 1'b1 || bus.cop_wen !== 1'b0)
      begin errors++; $display("FAIL lb_error: lde=%b wen=%b want 1 0", bus.cop_mem_ld_error, bus.cop_wen); end
    do_txn({7'd4, 5'd2, 5'd1, 3'b001, 5'd10, 7'h2B}, 32'h00F0_0000, 32'h0000_000F, 32'h0, 0, 1'b0, 1'b1);
    do_txn({12'h001, 5'd1, 3'b010, 5'd11, 7'h2B}, 32'hFFFF_FFFF, 32'h0, 32'h00AB_0000, 0, 1'b0, 1'b1);
  endtask

  task automatic test_illegal();
    do_txn({7'd0, 5'd2, 5'd1, 3'b001, 5'd3, 7'h33}, 32'h1, 32'h2, 32'h0, 0, 1'b0, 1'b0);
    do_txn({7'd6, 5'd2, 5'd1, 3'b001, 5'd3, 7'h2B}, 32'h1, 32'h2, 32'h0, 0, 1'b0, 1'b0);
    do_txn({7'd0, 5'd2, 5'd1, 3'b101, 5'd3, 7'h2B}, 32'h1, 32'h2, 32'h0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic [31:0] instr;
    int          cls;
    for (int i = 0; i < 60; i++) begin
      instr = $urandom;
      cls   = $urandom_range(0, 4);
      instr[6:0] = 7'h2B;
      case (cls)
        0: begin instr[14:12] = 3'b001; instr[31:25] = 7'($urandom_range(0, 5)); end
        1: instr[14:12] = 3'b010;
        2: instr[14:12] = 3'b011;
        3: instr[14:12] = 3'b000;
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            instr[6:0] = 7'($urandom_range(0, 127));
            if (instr[6:0] == 7'h2B) instr[6:0] = 7'h2A;
          end else begin
            instr[14:12] = 3'b001; instr[31:25] = 7'($urandom_range(6, 127));
          end
        end
      endcase
      do_txn(instr, $urandom, $urandom, $urandom, $urandom_range(0, 3),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clk);
    bus.cop_req = 1'b1; bus.cop_instr_in = {7'd0, 5'd2, 5'd1, 3'b000, 5'd2, 7'h2B};
    bus.cop_rs1 = 32'h0000_0300; bus.cop_rs2 = 32'h0000_00A5; bus.cop_mem_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cop_mem_cen !== 1'b0 || bus.cop_mem_wen !== 1'b1 || bus.cop_mem_ben !== 4'b0100)
      begin errors++; $display("FAIL mid_mem_setup: cen=%b wen=%b ben=%b want 0 1 0100", bus.cop_mem_cen, bus.cop_mem_wen, bus.cop_mem_ben); end
    resetn = 1'b1;
    #1;
    checks++;
    if (bus.cop_mem_cen !== 1'b1 || bus.cop_mem_wen !== 1'b0 || bus.cop_mem_ben !== 4'b0 ||
        bus.cop_mem_addr !== 32'h0 || bus.cop_mem_wdata !== 32'h0 || bus.cop_acc !== 1'b0 ||
        bus.cop_rsp !== 1'b0 || bus.cop_wdata !== 32'h0 || bus.cop_rd !== 5'd0 || bus.cop_wen !== 1'b0)
      begin errors++; $display("FAIL reset_mid_mem: cen=%b wen=%b ben=%b ma=%h mwd=%h acc=%b rsp=%b wd=%h rd=%0d cwen=%b",
        bus.cop_mem_cen, bus.cop_mem_wen, bus.cop_mem_ben, bus.cop_mem_addr, bus.cop_mem_wdata,
        bus.cop_acc, bus.cop_rsp, bus.cop_wdata, bus.cop_rd, bus.cop_wen); end
    @(negedge clk);
    resetn = 1'b0; bus.cop_req = 1'b0; bus.cop_mem_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.cop_rsp !== 1'b0 || bus.cop_mem_cen !== 1'b1)
        begin errors++; $display("FAIL aborted_txn: rsp=%b cen=%b want 0 1", bus.cop_rsp, bus.cop_mem_cen); end
    end
    do_txn({7'd1, 5'd2, 5'd1, 3'b001, 5'd4, 7'h2B}, 32'h0F0F_0F0F, 32'h0000_00FF, 32'h0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_xor_rb();
    test_and_rbk();
    test_lb_bk();
    test_sb_stall();
    test_lb_error_b2b();
    test_illegal();
    test_random();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
